// File: rtl/interrupt_controller_pkg.sv
// interrupt_controller_pkg: shared state encodings, cause codes and default vectors
package interrupt_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQUEST = 2'b01,
    SERVICE = 2'b10
  } state_t;

  // Cause codes double as one-hot masks into the pending vector.
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_OVF  = 2'b01;
  localparam logic [1:0] CAUSE_USER = 2'b10;

  localparam logic [15:0] DEF_OVF_VECTOR  = 16'h0010;
  localparam logic [15:0] DEF_USER_VECTOR = 16'h0020;

  // Fixed priority: overflow beats user input.
  function automatic logic [1:0] select_cause(input logic [1:0] pending);
    return pending[0] ? CAUSE_OVF : pending[1] ? CAUSE_USER : CAUSE_NONE;
  endfunction

endpackage

// File: rtl/interrupt_controller_pending_latch.sv
// pending_latch: user-input edge detector and sticky per-cause pending bits
module pending_latch (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_overflow,
  input  logic       i_user,
  input  logic       i_enable,
  input  logic [1:0] i_clr,
  output logic [1:0] o_pending
);

  logic       r_user_q;
  logic [1:0] r_pending;
  logic       w_user_event;
  logic [1:0] w_set;

  assign w_user_event = i_user & ~r_user_q;
  assign w_set        = {w_user_event, i_overflow};
  assign o_pending    = r_pending;

  // Track the user level; set beats clear, and a global disable drops everything.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_user_q  <= 1'b0;
      r_pending <= 2'b00;
    end else begin
      r_user_q  <= i_user;
      r_pending <= i_enable ? ((r_pending & ~i_clr) | w_set) : 2'b00;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches exception causes, requests the core and tracks handler mode
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] OVF_VECTOR  = WIDTH'(DEF_OVF_VECTOR),
  parameter logic [WIDTH-1:0] USER_VECTOR = WIDTH'(DEF_USER_VECTOR)
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             overflow,
  input  logic             userInput,
  input  logic             interruptsEnabled,
  input  logic [WIDTH-1:0] pc,
  input  logic             interruptAck,
  input  logic             rfi,
  output logic             interruptReq,
  output logic             mode,
  output logic [1:0]       cause,
  output logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] handlerAddr
);

  state_t           r_state;
  logic             r_req;
  logic             r_mode;
  logic [1:0]       r_cause;
  logic [WIDTH-1:0] r_epc;
  logic [1:0]       w_pending;
  logic [1:0]       w_sel;
  logic [1:0]       w_clr;
  logic             w_take;

  assign w_sel  = select_cause(w_pending);
  assign w_take = (r_state == REQUEST) && interruptAck;
  assign w_clr  = w_take ? w_sel : CAUSE_NONE;

  pending_latch u_pending (
    .i_clk     (CLK),
    .i_reset_n (reset_n),
    .i_overflow(overflow),
    .i_user    (userInput),
    .i_enable  (interruptsEnabled),
    .i_clr     (w_clr),
    .o_pending (w_pending)
  );

  // Request/service sequencing; ack wins over a simultaneous disable.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_mode  <= 1'b0;
      r_cause <= CAUSE_NONE;
      r_epc   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if ((w_pending != 2'b00) && interruptsEnabled) begin
            r_state <= REQUEST;
            r_req   <= 1'b1;
          end
        end
        REQUEST: begin
          if (interruptAck) begin
            r_state <= SERVICE;
            r_req   <= 1'b0;
            r_mode  <= 1'b1;
            r_epc   <= pc;
            r_cause <= w_sel;
          end else if (!interruptsEnabled) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
          end
        end
        SERVICE: begin
          if (rfi) begin
            r_state <= IDLE;
            r_mode  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_mode  <= 1'b0;
        end
      endcase
    end
  end

  assign interruptReq = r_req;
  assign mode         = r_mode;
  assign cause        = r_cause;
  assign epc          = r_epc;
  assign handlerAddr  = !r_req ? '0 :
                        (w_sel == CAUSE_OVF)  ? OVF_VECTOR :
                        (w_sel == CAUSE_USER) ? USER_VECTOR : '0;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed self-checking bench for interrupt_controller
module tb_interrupt_controller;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        overflow;
  logic        userInput;
  logic        interruptsEnabled;
  logic [15:0] pc;
  logic        interruptAck;
  logic        rfi;
  logic        interruptReq;
  logic        mode;
  logic [1:0]  cause;
  logic [15:0] epc;
  logic [15:0] handlerAddr;

  int n_checks = 0;
  int n_err    = 0;

  interrupt_controller dut (
    .CLK              (CLK),
    .reset_n          (reset_n),
    .overflow         (overflow),
    .userInput        (userInput),
    .interruptsEnabled(interruptsEnabled),
    .pc               (pc),
    .interruptAck     (interruptAck),
    .rfi              (rfi),
    .interruptReq     (interruptReq),
    .mode             (mode),
    .cause            (cause),
    .epc              (epc),
    .handlerAddr      (handlerAddr)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; overflow = 1'b1; userInput = 1'b0; interruptsEnabled = 1'b1;
    pc = 16'h0000; interruptAck = 1'b0; rfi = 1'b0;
    step(); step();
    chk("rst_req", interruptReq, 0);
    chk("rst_mode", mode, 0);
    chk("rst_cause", cause, 0);
    chk("rst_epc", epc, 0);
    chk("rst_haddr", handlerAddr, 0);
    reset_n = 1'b1;
    step();
    chk("rel_req_n1", interruptReq, 0);
    overflow = 1'b0;
    step();
    chk("rel_req_n2", interruptReq, 1);
    chk("rel_haddr", handlerAddr, 16'h0010);
    pc = 16'h0055; interruptAck = 1'b1;
    step();
    interruptAck = 1'b0;
    chk("rel_mode", mode, 1);
    chk("rel_cause", cause, 1);
    chk("rel_epc", epc, 16'h0055);
    rfi = 1'b1;
    step();
    rfi = 1'b0;
    chk("rel_rfi_mode", mode, 0);
    step();
    chk("rel_idle_req", interruptReq, 0);

    interruptAck = 1'b1; rfi = 1'b1; pc = 16'hFFFF;
    step();
    interruptAck = 1'b0; rfi = 1'b0;
    chk("stray_epc", epc, 16'h0055);
    chk("stray_mode", mode, 0);
    chk("stray_req", interruptReq, 0);

    overflow = 1'b1; pc = 16'h0123;
    step();
    overflow = 1'b0;
    chk("ovf_req_n1", interruptReq, 0);
    step();
    chk("ovf_req_n2", interruptReq, 1);
    chk("ovf_haddr", handlerAddr, 16'h0010);
    interruptAck = 1'b1;
    step();
    interruptAck = 1'b0;
    chk("ovf_mode", mode, 1);
    chk("ovf_req_drop", interruptReq, 0);
    chk("ovf_haddr_zero", handlerAddr, 0);
    chk("ovf_epc", epc, 16'h0123);
    chk("ovf_cause", cause, 1);
    rfi = 1'b1;
    step();
    rfi = 1'b0;
    chk("ovf_rfi_mode", mode, 0);
    chk("ovf_rfi_epc", epc, 16'h0123);
    chk("ovf_rfi_cause", cause, 1);

    overflow = 1'b1; userInput = 1'b1;
    step();
    overflow = 1'b0;
    step();
    chk("pri_req", interruptReq, 1);
    chk("pri_haddr1", handlerAddr, 16'h0010);
    pc = 16'h0321; interruptAck = 1'b1;
    step();
    interruptAck = 1'b0;
    chk("pri_cause1", cause, 1);
    rfi = 1'b1;
    step();
    rfi = 1'b0;
    chk("pri_gap_req", interruptReq, 0);
    step();
    chk("pri_req2", interruptReq, 1);
    chk("pri_haddr2", handlerAddr, 16'h0020);
    pc = 16'h0456; interruptAck = 1'b1;
    step();
    interruptAck = 1'b0;
    chk("pri_cause2", cause, 2);
    chk("pri_epc2", epc, 16'h0456);
    rfi = 1'b1;
    step();
    rfi = 1'b0; userInput = 1'b0;

    overflow = 1'b1;
    step(); step();
    overflow = 1'b0; interruptAck = 1'b1;
    step();
    interruptAck = 1'b0;
    chk("rep_cause", cause, 1);
    rfi = 1'b1;
    step();
    rfi = 1'b0;
    step(); step();
    chk("rep_no_rereq", interruptReq, 0);

    interruptsEnabled = 1'b0;
    for (int i = 0; i < 6; i++) begin
      overflow = i[0]; userInput = i[0];
      step();
      chk("dis_req", interruptReq, 0);
      chk("dis_mode", mode, 0);
    end
    overflow = 1'b0; userInput = 1'b0;
    step();
    interruptsEnabled = 1'b1;
    step(); step(); step();
    chk("dis_en_req", interruptReq, 0);

    overflow = 1'b1;
    step();
    overflow = 1'b0;
    step();
    interruptAck = 1'b1;
    step();
    interruptAck = 1'b0;
    chk("nest_mode", mode, 1);
    overflow = 1'b1;
    step();
    overflow = 1'b0;
    chk("nest_req1", interruptReq, 0);
    step();
    chk("nest_req2", interruptReq, 0);
    chk("nest_mode2", mode, 1);
    rfi = 1'b1;
    step();
    rfi = 1'b0;
    chk("nest_rfi_mode", mode, 0);
    step();
    chk("nest_rereq", interruptReq, 1);
    chk("nest_haddr", handlerAddr, 16'h0010);
    pc = 16'h0789; interruptAck = 1'b1;
    step();
    interruptAck = 1'b0;
    chk("nest_cause", cause, 1);
    chk("nest_epc", epc, 16'h0789);

    userInput = 1'b1;
    step();
    userInput = 1'b0;
    chk("mid_mode_pre", mode, 1);
    reset_n = 1'b0;
    step();
    chk("mid_mode", mode, 0);
    chk("mid_epc", epc, 0);
    chk("mid_cause", cause, 0);
    chk("mid_req", interruptReq, 0);
    reset_n = 1'b1;
    step(); step(); step();
    chk("mid_pending_clr", interruptReq, 0);

    userInput = 1'b1; reset_n = 1'b0;
    step();
    interruptsEnabled = 1'b0; reset_n = 1'b1;
    step();
    interruptsEnabled = 1'b1;
    step(); step(); step();
    chk("lvl_no_event", interruptReq, 0);
    chk("lvl_mode", mode, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
